// File: rtl/dma_cmd_responder.sv
// DMA command responder backed by a store of 2**ADDR_W 128-byte lines.
// Define DMA_RSP_SPLIT_EN to return each read as two 64-byte beats.
module dma_cmd_responder #(
  parameter int         ADDR_W    = 4,
  parameter logic [2:0] CODE_FAIL = 3'b010
) (
  input  logic          clk_afu,
  input  logic          rst,
  input  logic          dma_wr_cmd_valid,
  output logic          dma_wr_cmd_ready,
  input  logic [1023:0] dma_wr_cmd_data,
  input  logic [127:0]  dma_wr_cmd_be,
  input  logic [63:0]   dma_wr_cmd_ea,
  input  logic [5:0]    dma_wr_cmd_tag,
  input  logic          dma_rd_cmd_valid,
  output logic          dma_rd_cmd_ready,
  input  logic [63:0]   dma_rd_cmd_ea,
  input  logic [5:0]    dma_rd_cmd_tag,
  output logic          dma_wr_resp_valid,
  output logic [1023:0] dma_wr_resp_data,
  output logic [5:0]    dma_wr_resp_tag,
  output logic [1:0]    dma_wr_resp_pos,
  output logic [2:0]    dma_wr_resp_code,
  output logic          dma_rd_resp_valid,
  output logic [1023:0] dma_rd_resp_data,
  output logic [5:0]    dma_rd_resp_tag,
  output logic [1:0]    dma_rd_resp_pos,
  output logic [2:0]    dma_rd_resp_code,
  output logic [7:0]    outstanding_cnt
);

  localparam int LINES = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} rd_st_e;

  function automatic logic in_win(input logic [63:0] ea);
    return (ea[63:ADDR_W+7] == '0) && (ea[6:0] == 7'd0);
  endfunction

  logic [1023:0] mem_q [LINES];
  logic [1023:0] wline_d;

  logic              wr_acc, rd_acc, wr_win, rd_win;
  logic [ADDR_W-1:0] wr_idx, rd_idx;

  rd_st_e        st_q, st_d;
  logic          ws_v_q, ws_v_d;
  logic [5:0]    ws_tag_q, ws_tag_d;
  logic [2:0]    ws_code_q, ws_code_d;
  logic [5:0]    rs_tag_q, rs_tag_d;
  logic [2:0]    rs_code_q, rs_code_d;
  logic [1023:0] rs_data_q, rs_data_d;
  logic          wo_v_q, wo_v_d;
  logic [5:0]    wo_tag_q, wo_tag_d;
  logic [2:0]    wo_code_q, wo_code_d;
  logic          ro_v_q, ro_v_d;
  logic [5:0]    ro_tag_q, ro_tag_d;
  logic [1:0]    ro_pos_q, ro_pos_d;
  logic [2:0]    ro_code_q, ro_code_d;
  logic [1023:0] ro_data_q, ro_data_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [1:0]        inc, dec;
  logic signed [9:0] sum;

  assign wr_win = in_win(dma_wr_cmd_ea);
  assign rd_win = in_win(dma_rd_cmd_ea);
  assign wr_idx = dma_wr_cmd_ea[ADDR_W+6:7];
  assign rd_idx = dma_rd_cmd_ea[ADDR_W+6:7];

  assign dma_wr_cmd_ready = ~rst;
`ifdef DMA_RSP_SPLIT_EN
  assign dma_rd_cmd_ready = ~rst & (st_q != BEAT0);
`else
  assign dma_rd_cmd_ready = ~rst;
`endif

  assign wr_acc = dma_wr_cmd_valid & dma_wr_cmd_ready;
  assign rd_acc = dma_rd_cmd_valid & dma_rd_cmd_ready;

  always_comb begin
    wline_d = mem_q[wr_idx];
    for (int i = 0; i < 128; i++) begin
      if (dma_wr_cmd_be[i]) wline_d[8*i +: 8] = dma_wr_cmd_data[8*i +: 8];
    end
  end

  // Store reads sample the pre-write line on the same edge (read-first).
  always_ff @(posedge clk_afu) begin
    if (wr_acc && wr_win) mem_q[wr_idx] <= wline_d;
  end

  always_comb begin
    ws_v_d    = wr_acc;
    ws_tag_d  = wr_acc ? dma_wr_cmd_tag : 6'd0;
    ws_code_d = (wr_acc && !wr_win) ? CODE_FAIL : 3'b000;
    wo_v_d    = ws_v_q;
    wo_tag_d  = ws_tag_q;
    wo_code_d = ws_code_q;

    rs_tag_d  = rs_tag_q;
    rs_code_d = rs_code_q;
    rs_data_d = rs_data_q;
    if (rd_acc) begin
      rs_tag_d  = dma_rd_cmd_tag;
      rs_code_d = rd_win ? 3'b000 : CODE_FAIL;
      rs_data_d = rd_win ? mem_q[rd_idx] : '0;
    end

    st_d      = st_q;
    ro_v_d    = 1'b0;
    ro_tag_d  = 6'd0;
    ro_pos_d  = 2'b00;
    ro_code_d = 3'b000;
    ro_data_d = '0;
    unique case (st_q)
      IDLE: st_d = rd_acc ? BEAT0 : IDLE;
      BEAT0: begin
        ro_v_d    = 1'b1;
        ro_tag_d  = rs_tag_q;
        ro_code_d = rs_code_q;
`ifdef DMA_RSP_SPLIT_EN
        ro_pos_d  = 2'b01;
        ro_data_d = {512'd0, rs_data_q[511:0]};
        st_d      = BEAT1;
`else
        ro_data_d = rs_data_q;
        st_d      = rd_acc ? BEAT0 : IDLE;
`endif
      end
      BEAT1: begin
        ro_v_d    = 1'b1;
        ro_tag_d  = rs_tag_q;
        ro_code_d = rs_code_q;
        ro_pos_d  = 2'b10;
        ro_data_d = {512'd0, rs_data_q[1023:512]};
        st_d      = rd_acc ? BEAT0 : IDLE;
      end
      default: st_d = IDLE;
    endcase

    // A split read only retires on its second beat.
    inc = {1'b0, wr_acc} + {1'b0, rd_acc};
    dec = {1'b0, wo_v_q} + {1'b0, ro_v_q & (ro_pos_q != 2'b01)};
    sum = $signed({2'b00, cnt_q}) + $signed({8'd0, inc})
        - $signed({8'd0, dec});
    if (sum > 10'sd255)    cnt_d = 8'hff;
    else if (sum < 10'sd0) cnt_d = 8'd0;
    else                   cnt_d = sum[7:0];
  end

  always_ff @(posedge clk_afu) begin
    if (rst) begin
      st_q      <= IDLE;
      ws_v_q    <= 1'b0;
      ws_tag_q  <= 6'd0;
      ws_code_q <= 3'b000;
      rs_tag_q  <= 6'd0;
      rs_code_q <= 3'b000;
      rs_data_q <= '0;
      wo_v_q    <= 1'b0;
      wo_tag_q  <= 6'd0;
      wo_code_q <= 3'b000;
      ro_v_q    <= 1'b0;
      ro_tag_q  <= 6'd0;
      ro_pos_q  <= 2'b00;
      ro_code_q <= 3'b000;
      ro_data_q <= '0;
      cnt_q     <= 8'd0;
    end else begin
      st_q      <= st_d;
      ws_v_q    <= ws_v_d;
      ws_tag_q  <= ws_tag_d;
      ws_code_q <= ws_code_d;
      rs_tag_q  <= rs_tag_d;
      rs_code_q <= rs_code_d;
      rs_data_q <= rs_data_d;
      wo_v_q    <= wo_v_d;
      wo_tag_q  <= wo_tag_d;
      wo_code_q <= wo_code_d;
      ro_v_q    <= ro_v_d;
      ro_tag_q  <= ro_tag_d;
      ro_pos_q  <= ro_pos_d;
      ro_code_q <= ro_code_d;
      ro_data_q <= ro_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dma_wr_resp_valid = wo_v_q & ~rst;
  assign dma_wr_resp_data  = '0;
  assign dma_wr_resp_tag   = rst ? 6'd0 : wo_tag_q;
  assign dma_wr_resp_pos   = 2'b00;
  assign dma_wr_resp_code  = rst ? 3'b000 : wo_code_q;
  assign dma_rd_resp_valid = ro_v_q & ~rst;
  assign dma_rd_resp_data  = rst ? '0 : ro_data_q;
  assign dma_rd_resp_tag   = rst ? 6'd0 : ro_tag_q;
  assign dma_rd_resp_pos   = rst ? 2'b00 : ro_pos_q;
  assign dma_rd_resp_code  = rst ? 3'b000 : ro_code_q;
  assign outstanding_cnt   = rst ? 8'd0 : cnt_q;

endmodule

// File: tb/tb_dma_cmd_responder.sv
// Bench for dma_cmd_responder: directed cases plus randomized traffic
// against a cycle-scheduled behavioural model of the response stream.
module tb_dma_cmd_responder;

  localparam int AW = 4;
`ifdef DMA_RSP_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk_afu = 1'b0;
  logic          rst = 1'b1;
  logic          dma_wr_cmd_valid = 1'b0;
  logic          dma_wr_cmd_ready;
  logic [1023:0] dma_wr_cmd_data = '0;
  logic [127:0]  dma_wr_cmd_be = '0;
  logic [63:0]   dma_wr_cmd_ea = '0;
  logic [5:0]    dma_wr_cmd_tag = '0;
  logic          dma_rd_cmd_valid = 1'b0;
  logic          dma_rd_cmd_ready;
  logic [63:0]   dma_rd_cmd_ea = '0;
  logic [5:0]    dma_rd_cmd_tag = '0;
  logic          dma_wr_resp_valid;
  logic [1023:0] dma_wr_resp_data;
  logic [5:0]    dma_wr_resp_tag;
  logic [1:0]    dma_wr_resp_pos;
  logic [2:0]    dma_wr_resp_code;
  logic          dma_rd_resp_valid;
  logic [1023:0] dma_rd_resp_data;
  logic [5:0]    dma_rd_resp_tag;
  logic [1:0]    dma_rd_resp_pos;
  logic [2:0]    dma_rd_resp_code;
  logic [7:0]    outstanding_cnt;

  always #5 clk_afu = ~clk_afu;

  dma_cmd_responder dut (
    .clk_afu(clk_afu), .rst(rst),
    .dma_wr_cmd_valid(dma_wr_cmd_valid), .dma_wr_cmd_ready(dma_wr_cmd_ready),
    .dma_wr_cmd_data(dma_wr_cmd_data), .dma_wr_cmd_be(dma_wr_cmd_be),
    .dma_wr_cmd_ea(dma_wr_cmd_ea), .dma_wr_cmd_tag(dma_wr_cmd_tag),
    .dma_rd_cmd_valid(dma_rd_cmd_valid), .dma_rd_cmd_ready(dma_rd_cmd_ready),
    .dma_rd_cmd_ea(dma_rd_cmd_ea), .dma_rd_cmd_tag(dma_rd_cmd_tag),
    .dma_wr_resp_valid(dma_wr_resp_valid), .dma_wr_resp_data(dma_wr_resp_data),
    .dma_wr_resp_tag(dma_wr_resp_tag), .dma_wr_resp_pos(dma_wr_resp_pos),
    .dma_wr_resp_code(dma_wr_resp_code),
    .dma_rd_resp_valid(dma_rd_resp_valid), .dma_rd_resp_data(dma_rd_resp_data),
    .dma_rd_resp_tag(dma_rd_resp_tag), .dma_rd_resp_pos(dma_rd_resp_pos),
    .dma_rd_resp_code(dma_rd_resp_code),
    .outstanding_cnt(outstanding_cnt)
  );

  typedef struct {
    logic          v;
    logic [5:0]    tag;
    logic [1:0]    pos;
    logic [2:0]    code;
    logic [1023:0] data;
  } rsp_t;
  typedef struct {int cyc; logic [5:0] tag; logic [2:0] code;} wlog_t;
  typedef struct {int cyc; logic [5:0] tag; logic [2:0] code; logic [1023:0] data;} rlog_t;
  typedef struct {int cyc; logic [1:0] pos; logic [5:0] tag;} blog_t;

  logic [1023:0] mm [16];
  logic [1023:0] initv [16];
  rsp_t  wexp [8];
  rsp_t  rexp [8];
  wlog_t wlog [$];
  rlog_t rlog [$];
  blog_t blog [$];
  logic [511:0] pend_lo;
  int pend_cyc;
  int cyc = 0;
  int cnt_m = 0;
  logic prev_ra = 1'b0;
  int errors = 0;
  int checks = 0;

  function automatic rsp_t mk(logic v, logic [5:0] t, logic [1:0] p,
                              logic [2:0] c, logic [1023:0] d);
    rsp_t r;
    r.v = v; r.tag = t; r.pos = p; r.code = c; r.data = d;
    return r;
  endfunction

  function automatic logic win(logic [63:0] ea);
    return ((ea >> (AW + 7)) == 64'd0) && ((ea & 64'h7f) == 64'd0);
  endfunction

  function automatic logic [1023:0] r1k();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic ck(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic ckd(string nm, logic [1023:0] act, logic [1023:0] exp);
    int k;
    checks++;
    if (act !== exp) begin
      errors++;
      k = 0;
      for (int i = 31; i >= 0; i--)
        if (act[32*i +: 32] !== exp[32*i +: 32]) k = i;
      $display("FAIL %s cyc=%0d word%0d actual=%h required=%h",
               nm, cyc, k, act[32*k +: 32], exp[32*k +: 32]);
    end
  endtask

  // One clock cycle: compare outputs, log responses, advance the model.
  task automatic step();
    rsp_t we, re;
    int s, fin, n, li;
    logic erw, err, wa, ra;
    logic [1023:0] line;
    logic [2:0] code;
    #1;
    s = cyc % 8;
    we = wexp[s];
    re = rexp[s];
    if (rst) begin
      we = mk(0, 0, 0, 0, '0);
      re = mk(0, 0, 0, 0, '0);
    end
    erw = !rst;
    err = !rst && !(SPLIT && prev_ra);
    ck("wr_cmd_ready", dma_wr_cmd_ready, erw);
    ck("rd_cmd_ready", dma_rd_cmd_ready, err);
    ck("wr_resp_valid", dma_wr_resp_valid, we.v);
    if (we.v || rst) begin
      ck("wr_resp_tag", dma_wr_resp_tag, we.tag);
      ck("wr_resp_pos", dma_wr_resp_pos, 0);
      ck("wr_resp_code", dma_wr_resp_code, we.code);
      ckd("wr_resp_data", dma_wr_resp_data, '0);
    end
    ck("rd_resp_valid", dma_rd_resp_valid, re.v);
    if (re.v || rst) begin
      ck("rd_resp_tag", dma_rd_resp_tag, re.tag);
      ck("rd_resp_pos", dma_rd_resp_pos, re.pos);
      ck("rd_resp_code", dma_rd_resp_code, re.code);
      ckd("rd_resp_data", dma_rd_resp_data, re.data);
    end
    ck("outstanding_cnt", outstanding_cnt, rst ? 0 : cnt_m);

    if (dma_wr_resp_valid)
      wlog.push_back('{cyc: cyc, tag: dma_wr_resp_tag, code: dma_wr_resp_code});
    if (dma_rd_resp_valid) begin
      blog.push_back('{cyc: cyc, pos: dma_rd_resp_pos, tag: dma_rd_resp_tag});
      if (dma_rd_resp_pos == 2'b01) begin
        pend_lo = dma_rd_resp_data[511:0];
        pend_cyc = cyc;
      end else if (dma_rd_resp_pos == 2'b10) begin
        rlog.push_back('{cyc: pend_cyc, tag: dma_rd_resp_tag, code: dma_rd_resp_code,
                         data: {dma_rd_resp_data[511:0], pend_lo}});
      end else begin
        rlog.push_back('{cyc: cyc, tag: dma_rd_resp_tag, code: dma_rd_resp_code,
                         data: dma_rd_resp_data});
      end
    end

    fin = int'(wexp[s].v) + int'(rexp[s].v && rexp[s].pos != 2'b01);
    wexp[s] = mk(0, 0, 0, 0, '0);
    rexp[s] = mk(0, 0, 0, 0, '0);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        wexp[i] = mk(0, 0, 0, 0, '0);
        rexp[i] = mk(0, 0, 0, 0, '0);
      end
      cnt_m = 0;
      prev_ra = 1'b0;
    end else begin
      wa = dma_wr_cmd_valid && erw;
      ra = dma_rd_cmd_valid && err;
      if (ra) begin
        li = int'((dma_rd_cmd_ea >> 7) % 16);
        line = win(dma_rd_cmd_ea) ? mm[li] : '0;
        code = win(dma_rd_cmd_ea) ? 3'b000 : 3'b010;
        if (SPLIT) begin
          rexp[(cyc+2)%8] = mk(1, dma_rd_cmd_tag, 2'b01, code, {512'd0, line[511:0]});
          rexp[(cyc+3)%8] = mk(1, dma_rd_cmd_tag, 2'b10, code, {512'd0, line[1023:512]});
        end else begin
          rexp[(cyc+2)%8] = mk(1, dma_rd_cmd_tag, 2'b00, code, line);
        end
      end
      if (wa) begin
        code = win(dma_wr_cmd_ea) ? 3'b000 : 3'b010;
        wexp[(cyc+2)%8] = mk(1, dma_wr_cmd_tag, 2'b00, code, '0);
        if (win(dma_wr_cmd_ea)) begin
          li = int'((dma_wr_cmd_ea >> 7) % 16);
          for (int b = 0; b < 128; b++)
            if (dma_wr_cmd_be[b]) mm[li][8*b +: 8] = dma_wr_cmd_data[8*b +: 8];
        end
      end
      n = cnt_m + int'(wa) + int'(ra) - fin;
      cnt_m = (n > 255) ? 255 : ((n < 0) ? 0 : n);
      prev_ra = ra;
    end
    cyc++;
    @(negedge clk_afu);
  endtask

  task automatic idle(int n);
    dma_wr_cmd_valid = 1'b0;
    dma_rd_cmd_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic set_wr(logic [63:0] ea, logic [127:0] be,
                        logic [1023:0] d, logic [5:0] t);
    dma_wr_cmd_valid = 1'b1;
    dma_wr_cmd_ea = ea;
    dma_wr_cmd_be = be;
    dma_wr_cmd_data = d;
    dma_wr_cmd_tag = t;
  endtask

  task automatic rd_issue(logic [63:0] ea, logic [5:0] t, output int acc);
    logic rdy;
    int c;
    dma_rd_cmd_valid = 1'b1;
    dma_rd_cmd_ea = ea;
    dma_rd_cmd_tag = t;
    acc = -1;
    for (int g = 0; g < 4; g++) begin
      rdy = dma_rd_cmd_ready;
      c = cyc;
      step();
      dma_wr_cmd_valid = 1'b0;
      if (rdy) begin
        acc = c;
        break;
      end
    end
    dma_rd_cmd_valid = 1'b0;
  endtask

  task automatic get_rd(int k, output rlog_t r);
    if (k < rlog.size()) r = rlog[k];
    else r = '{cyc: -1, tag: 6'h3f, code: 3'b111, data: '1};
  endtask

  task automatic get_wr(int k, output wlog_t w);
    if (k < wlog.size()) w = wlog[k];
    else w = '{cyc: -1, tag: 6'h3f, code: 3'b111};
  endtask

  task automatic clr_logs();
    wlog.delete();
    rlog.delete();
    blog.delete();
  endtask

  initial begin
    logic [1023:0] pat_a, tmp, n3;
    rlog_t r;
    wlog_t w;
    int acc, a2;
    for (int i = 0; i < 8; i++) begin
      wexp[i] = mk(0, 0, 0, 0, '0);
      rexp[i] = mk(0, 0, 0, 0, '0);
    end
    @(negedge clk_afu);
    idle(3);
    rst = 1'b0;
    #1;
    ck("post_rst_wr_ready", dma_wr_cmd_ready, 1);
    ck("post_rst_rd_ready", dma_rd_cmd_ready, 1);
    ck("post_rst_cnt", outstanding_cnt, 0);

    for (int i = 0; i < 16; i++) begin
      initv[i] = r1k();
      set_wr(64'(i) << 7, '1, initv[i], 6'(i));
      step();
    end
    idle(3);

    // Full-line write then read back
    clr_logs();
    pat_a = {8{128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210}};
    set_wr(64'h80, '1, pat_a, 6'd5);
    acc = cyc;
    step();
    idle(3);
    get_wr(0, w);
    ck("t27_wr_lat", w.cyc - acc, 2);
    ck("t27_wr_tag", w.tag, 5);
    ck("t27_wr_code", w.code, 0);
    rd_issue(64'h80, 6'd9, acc);
    idle(4);
    get_rd(0, r);
    ck("t27_rd_lat", r.cyc - acc, 2);
    ck("t27_rd_tag", r.tag, 9);
    ckd("t27_rd_data", r.data, pat_a);

    // Single-byte enable
    clr_logs();
    set_wr(64'h100, 128'h1, 1024'hff, 6'd20);
    step();
    dma_wr_cmd_valid = 1'b0;
    rd_issue(64'h100, 6'd21, acc);
    idle(4);
    tmp = initv[2];
    tmp[7:0] = 8'hff;
    get_rd(0, r);
    ckd("t28_byte0", r.data, tmp);

    // Out-of-window accesses
    clr_logs();
    rd_issue(64'h40, 6'd1, acc);
    idle(1);
    rd_issue(64'h1 << 20, 6'd2, acc);
    set_wr(64'h1 << 20, '1, r1k(), 6'd3);
    step();
    set_wr(64'h40, '1, r1k(), 6'd4);
    step();
    dma_wr_cmd_valid = 1'b0;
    rd_issue(64'h0, 6'd6, acc);
    idle(4);
    get_rd(0, r);
    ck("t29_misal_code", r.code, 3'b010);
    ckd("t29_misal_data", r.data, '0);
    get_rd(1, r);
    ck("t29_high_code", r.code, 3'b010);
    ckd("t29_high_data", r.data, '0);
    get_wr(0, w);
    ck("t29_wr_high_code", w.code, 3'b010);
    get_wr(1, w);
    ck("t29_wr_misal_code", w.code, 3'b010);
    get_rd(2, r);
    ckd("t29_line0_kept", r.data, initv[0]);

    // Same-cycle write/read on line 3, then read again
    clr_logs();
    n3 = r1k();
    set_wr(64'h180, '1, n3, 6'd10);
    rd_issue(64'h180, 6'd11, acc);
    rd_issue(64'h180, 6'd12, a2);
    idle(5);
    get_rd(0, r);
    ck("t30_tag_old", r.tag, 11);
    ckd("t30_read_first", r.data, initv[3]);
    get_rd(1, r);
    ck("t30_tag_new", r.tag, 12);
    ckd("t30_read_after", r.data, n3);

`ifdef DMA_RSP_SPLIT_EN
    clr_logs();
    rd_issue(64'h200, 6'd7, acc);
    ck("t31_rdy_low", dma_rd_cmd_ready, 0);
    idle(4);
    ck("t31_beats", blog.size(), 2);
    ck("t31_b0_pos", blog.size() > 0 ? blog[0].pos : 2'b11, 2'b01);
    ck("t31_b1_pos", blog.size() > 1 ? blog[1].pos : 2'b11, 2'b10);
    ck("t31_b0_lat", blog.size() > 0 ? blog[0].cyc - acc : -1, 2);
    ck("t31_b1_lat", blog.size() > 1 ? blog[1].cyc - acc : -1, 3);
    ck("t31_b1_tag", blog.size() > 1 ? blog[1].tag : 6'h3f, 7);
`endif

    // Reset with three commands in flight
    set_wr(64'h280, '1, r1k(), 6'd30);
    dma_rd_cmd_valid = 1'b1;
    dma_rd_cmd_ea = 64'h300;
    dma_rd_cmd_tag = 6'd31;
    step();
    dma_rd_cmd_valid = 1'b0;
    set_wr(64'h380, '1, r1k(), 6'd32);
    step();
    dma_wr_cmd_valid = 1'b0;
    ck("t32_cnt_pre", outstanding_cnt, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    ck("t32_wr_ready", dma_wr_cmd_ready, 1);
    ck("t32_rd_ready", dma_rd_cmd_ready, 1);
    clr_logs();
    idle(5);
    ck("t32_no_wr_resp", wlog.size(), 0);
    ck("t32_no_rd_resp", blog.size(), 0);
    ck("t32_cnt", outstanding_cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] ea;
      int k;
      rst = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < 2; p++) begin
        k = $urandom_range(0, 9);
        ea = 64'($urandom_range(0, 15)) << 7;
        if (k == 8) ea = ea | 64'($urandom_range(1, 127));
        if (k == 9) ea = ea | (64'h1 << $urandom_range(11, 63));
        if (p == 0) begin
          dma_wr_cmd_valid = $urandom_range(0, 1) == 1;
          dma_wr_cmd_ea = ea;
          dma_wr_cmd_data = r1k();
          dma_wr_cmd_be = $urandom_range(0, 3) == 0 ? '1 : r1k()[127:0];
          dma_wr_cmd_tag = 6'($urandom);
        end else begin
          dma_rd_cmd_valid = $urandom_range(0, 1) == 1;
          dma_rd_cmd_ea = ea;
          dma_rd_cmd_tag = 6'($urandom);
        end
      end
      step();
    end
    rst = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
